// File: rtl/regfile_sb.sv
// Integer register file: two combinational read ports, one byte-masked write port,
// optional same-cycle write-to-read forwarding, and a per-register busy scoreboard.

module regfile_sb_rdport #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]     rs_i,
  input  logic [XLEN-1:0]   stored_i,
  input  logic              busy_i,
  input  logic              regwrite_i,
  input  logic [AW-1:0]     rd_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN/8-1:0] wstrb_i,
  output logic [XLEN-1:0]   rdata_o,
  output logic              hazard_o
);
  localparam int NB = XLEN / 8;

  logic fwd;
  assign fwd = (BYPASS != 0) && regwrite_i && (rd_i == rs_i) && (rs_i != '0);

  // Forwarded value is a byte merge, so partial strobes still clear the hazard.
  always_comb begin
    rdata_o = '0;
    if (rs_i != '0) begin
      for (int b = 0; b < NB; b++)
        rdata_o[8*b +: 8] = (fwd && wstrb_i[b]) ? wdata_i[8*b +: 8] : stored_i[8*b +: 8];
    end
  end

  assign hazard_o = busy_i && (rs_i != '0) && !fwd;
endmodule

module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG),
  localparam int NB    = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] readdata1,
  output logic [XLEN-1:0] readdata2,
  input  logic            regwrite,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] writedata,
  input  logic [NB-1:0]   wstrb,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  output logic            hazard1,
  output logic            hazard2,
  output logic [AW:0]     busy_cnt
);
  logic [NREG-1:0][XLEN-1:0] regs_q;
  logic [NREG-1:0]           busy_q, busy_d;
  logic [AW:0]               cnt_q, cnt_d;
  logic                      set, clr, inc, dec;

  assign set = issue_en && (issue_rd != '0);
  assign clr = regwrite && (rd != '0);

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      for (int r = 1; r < NREG; r++)
        for (int b = 0; b < NB; b++)
          if (clr && (rd == AW'(r)) && wstrb[b])
            regs_q[r][8*b +: 8] <= writedata[8*b +: 8];
    end
  end

  // Set is applied after clear so a new producer on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr) busy_d[rd] = 1'b0;
    if (set) busy_d[issue_rd] = 1'b1;
  end

  assign inc   = set && !busy_q[issue_rd];
  assign dec   = clr && busy_q[rd] && !(set && (issue_rd == rd));
  assign cnt_d = cnt_q + (AW+1)'(inc) - (AW+1)'(dec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  logic [1:0][AW-1:0]   rs_v;
  logic [1:0][XLEN-1:0] rdata_v;
  logic [1:0]           haz_v;

  assign rs_v = {rs2, rs1};

  for (genvar p = 0; p < 2; p++) begin : g_rp
    regfile_sb_rdport #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rp (
      .rs_i       (rs_v[p]),
      .stored_i   (regs_q[rs_v[p]]),
      .busy_i     (busy_q[rs_v[p]]),
      .regwrite_i (regwrite),
      .rd_i       (rd),
      .wdata_i    (writedata),
      .wstrb_i    (wstrb),
      .rdata_o    (rdata_v[p]),
      .hazard_o   (haz_v[p])
    );
  end

  assign readdata1 = rdata_v[0];
  assign readdata2 = rdata_v[1];
  assign hazard1   = haz_v[0];
  assign hazard2   = haz_v[1];
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one forwarding instance and one non-forwarding
// instance share all inputs so bypass behaviour can be compared cycle by cycle.

module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd, issue_rd;
  logic        regwrite, issue_en;
  logic [31:0] writedata;
  logic [3:0]  wstrb;

  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        hz1_b, hz2_b, hz1_n, hz2_n;
  logic [5:0]  cnt_b, cnt_n;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
    .readdata1(rd1_b), .readdata2(rd2_b),
    .regwrite(regwrite), .rd(rd), .writedata(writedata), .wstrb(wstrb),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .hazard1(hz1_b), .hazard2(hz2_b), .busy_cnt(cnt_b)
  );

  regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
    .readdata1(rd1_n), .readdata2(rd2_n),
    .regwrite(regwrite), .rd(rd), .writedata(writedata), .wstrb(wstrb),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .hazard1(hz1_n), .hazard2(hz2_n), .busy_cnt(cnt_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    regwrite = 1'b0; issue_en = 1'b0; rd = '0; issue_rd = '0;
    writedata = '0; wstrb = '0;
  endtask

  initial begin
    rst_n = 1'b0; rs1 = '0; rs2 = '0;
    idle();
    #12 rst_n = 1'b1;
    tick();

    // Reset state
    rs1 = 5; rs2 = 31; #1;
    chk("rst_rd1", rd1_b, 32'h0);
    chk("rst_rd2", rd2_b, 32'h0);
    chk("rst_hz1", {31'b0, hz1_b}, 32'h0);
    chk("rst_hz2", {31'b0, hz2_b}, 32'h0);
    chk("rst_cnt", {26'b0, cnt_b}, 32'h0);

    // Full then partial write to x9; partial write also forwarded same cycle
    regwrite = 1; rd = 9; writedata = 32'h11223344; wstrb = 4'hF;
    tick();
    writedata = 32'hAABBCCDD; wstrb = 4'b0101; rs1 = 9; #1;
    chk("part_fwd_b", rd1_b, 32'h11BB33DD);
    chk("part_fwd_nb", rd1_n, 32'h11223344);
    tick();
    idle(); #1;
    chk("part_b", rd1_b, 32'h11BB33DD);
    chk("part_nb", rd1_n, 32'h11BB33DD);
    regwrite = 1; rd = 0; writedata = 32'hFFFFFFFF; wstrb = 4'hF;
    tick();
    idle(); rs1 = 0; #1;
    chk("x0_zero", rd1_b, 32'h0);

    // Bypass vs. no bypass
    regwrite = 1; rd = 3; writedata = 32'h3; wstrb = 4'hF;
    tick();
    writedata = 32'h77; rs1 = 3; #1;
    chk("byp_b", rd1_b, 32'h77);
    chk("byp_nb_now", rd1_n, 32'h3);
    tick();
    idle(); #1;
    chk("byp_nb_next", rd1_n, 32'h77);

    // Scoreboard set / clear
    issue_en = 1; issue_rd = 7;
    tick();
    idle(); rs2 = 7; #1;
    chk("sb_hz2", {31'b0, hz2_b}, 32'h1);
    chk("sb_cnt1", {26'b0, cnt_b}, 32'h1);
    regwrite = 1; rd = 7; writedata = 32'h1; wstrb = 4'hF; #1;
    chk("sb_hz2_byp", {31'b0, hz2_b}, 32'h0);
    chk("sb_hz2_nb", {31'b0, hz2_n}, 32'h1);
    tick();
    idle(); #1;
    chk("sb_cnt0", {26'b0, cnt_b}, 32'h0);
    chk("sb_hz2_nb_clr", {31'b0, hz2_n}, 32'h0);
    issue_en = 1; issue_rd = 0;
    tick();
    idle(); rs2 = 0; #1;
    chk("sb_issue_x0", {26'b0, cnt_b}, 32'h0);
    chk("sb_hz_x0", {31'b0, hz2_b}, 32'h0);

    // Simultaneous set and clear on x4
    issue_en = 1; issue_rd = 4;
    tick();
    regwrite = 1; rd = 4; writedata = 32'h55; wstrb = 4'hF;
    tick();
    idle(); rs1 = 4; #1;
    chk("sc_data", rd1_b, 32'h55);
    chk("sc_hz1", {31'b0, hz1_b}, 32'h1);
    chk("sc_cnt", {26'b0, cnt_b}, 32'h1);
    // Set x5 while clearing x4: net 0
    issue_en = 1; issue_rd = 5; regwrite = 1; rd = 4; writedata = 32'h56; wstrb = 4'hF;
    tick();
    idle(); rs2 = 5; #1;
    chk("sc2_cnt", {26'b0, cnt_b}, 32'h1);
    chk("sc2_hz1", {31'b0, hz1_b}, 32'h0);
    chk("sc2_hz2", {31'b0, hz2_b}, 32'h1);
    // Clear of non-busy register, then re-issue to busy x5: both leave count
    regwrite = 1; rd = 10; writedata = 32'h1; wstrb = 4'hF;
    tick();
    idle(); #1;
    chk("nb_clr_cnt", {26'b0, cnt_b}, 32'h1);
    issue_en = 1; issue_rd = 5;
    tick();
    idle(); #1;
    chk("reissue_cnt", {26'b0, cnt_b}, 32'h1);

    // Build x6,x8 busy with x6=0x99, then reset between edges
    issue_en = 1; issue_rd = 6; regwrite = 1; rd = 5; writedata = 32'h0; wstrb = 4'h0;
    tick();
    issue_en = 1; issue_rd = 6; regwrite = 1; rd = 6; writedata = 32'h99; wstrb = 4'hF;
    tick();
    idle(); issue_en = 1; issue_rd = 8;
    tick();
    idle(); rs1 = 6; rs2 = 8; #1;
    chk("pre_rst_cnt", {26'b0, cnt_b}, 32'h2);
    chk("pre_rst_x6", rd1_b, 32'h99);
    chk("pre_rst_hz1", {31'b0, hz1_b}, 32'h1);
    chk("pre_rst_hz2", {31'b0, hz2_b}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", {26'b0, cnt_b}, 32'h0);
    chk("mid_rst_hz1", {31'b0, hz1_b}, 32'h0);
    chk("mid_rst_hz2", {31'b0, hz2_b}, 32'h0);
    chk("mid_rst_x6", rd1_b, 32'h0);
    #3 rst_n = 1'b1;
    tick(); #1;
    chk("post_rst_hz1", {31'b0, hz1_b}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
